// File: rtl/osu_serial_sub_pkg.sv
// osu_serial_sub_pkg: shared state encoding and counter sizing for the serial subtractor
package osu_serial_sub_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r < 1 ? 1 : r;
    endfunction

endpackage

// File: rtl/osu_sub_bitslice.sv
// osu_sub_bitslice: combinational one-bit full subtractor (a - b - br)
module osu_sub_bitslice (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/osu_serial_subtractor.sv
// osu_serial_subtractor: bit-serial LSB-first A - B with valid/ready in and out.
// Define OSU_SERIAL_SUB_BORROW_IN_EN to add a BI borrow-in port for cascading.
module osu_serial_subtractor
    import osu_serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef OSU_SERIAL_SUB_BORROW_IN_EN
    input  logic             BI,
`endif
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BO
);

    localparam int CW = clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, d_r;
    logic [CW-1:0]    cnt;
    logic             br, bo_r, d_bit, br_next, last, bi_in;

`ifdef OSU_SERIAL_SUB_BORROW_IN_EN
    assign bi_in = BI;
`else
    assign bi_in = 1'b0;
`endif

    osu_sub_bitslice u_slice (
        .a      (sa[0]),
        .b      (sb[0]),
        .br     (br),
        .d      (d_bit),
        .br_next(br_next)
    );

    assign last = cnt == CW'(WIDTH - 1);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (IN_VALID ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : (OUT_READY ? IDLE : DONE);
    end

    // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sa   <= '0;
            sb   <= '0;
            d_r  <= '0;
            bo_r <= 1'b0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == IDLE && IN_VALID) begin
            sa  <= A;
            sb  <= B;
            br  <= bi_in;
            cnt <= '0;
        end else if (state == RUN) begin
            d_r <= {d_bit, d_r[WIDTH-1:1]};
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_next;
            cnt <= cnt + 1'b1;
            if (last) bo_r <= br_next;
        end
    end

    assign IN_READY  = state == IDLE;
    assign OUT_VALID = state == DONE;
    assign D         = d_r;
    assign BO        = bo_r;

endmodule

// File: tb/tb_osu_serial_subtractor.sv
// tb_osu_serial_subtractor: random and directed checks against an arithmetic model of A - B - BI
module tb_osu_serial_subtractor;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST, IN_VALID, OUT_READY, BI;
    logic [WIDTH-1:0] A, B, D;
    logic             IN_READY, OUT_VALID, BO;

    int total = 0;
    int bad   = 0;

    osu_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
`ifdef OSU_SERIAL_SUB_BORROW_IN_EN
        .BI       (BI),
`endif
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .D        (D),
        .BO       (BO)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a job takes WIDTH cycles after acceptance, then waits for OUT_READY.
    bit               m_run = 0, m_done = 0, m_bo = 0, m_res_bo = 0;
    int               m_busy = 0;
    logic [WIDTH-1:0] m_d = '0, m_res_d = '0;
    logic             bi_eff;

`ifdef OSU_SERIAL_SUB_BORROW_IN_EN
    assign bi_eff = BI;
`else
    assign bi_eff = 1'b0;
`endif

    always @(posedge CLK) begin
        if (RST) begin
            m_run = 0; m_done = 0; m_busy = 0; m_d = '0; m_bo = 0;
        end else if (m_done) begin
            if (OUT_READY) m_done = 0;
        end else if (m_run) begin
            m_busy--;
            if (m_busy == 0) begin
                m_run = 0; m_done = 1; m_d = m_res_d; m_bo = m_res_bo;
            end
        end else if (IN_VALID) begin
            m_run  = 1;
            m_busy = WIDTH;
            {m_res_bo, m_res_d} = {1'b0, A} - {1'b0, B} - (WIDTH + 1)'(bi_eff);
        end
    end

    always @(negedge CLK) begin
        cmp("in_ready", int'(IN_READY), int'(!m_run && !m_done));
        cmp("out_valid", int'(OUT_VALID), int'(m_done));
        cmp("bo", int'(BO), int'(m_bo));
        if (!m_run) cmp("d", int'(D), int'(m_d));
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input int stall, input bit noise,
                          output logic [WIDTH-1:0] d, output logic bo);
        int n;
        @(negedge CLK);
        A = a; B = b; BI = bi; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(negedge CLK);
        if (!noise) IN_VALID = 1'b0;
        n = 0;
        while (!OUT_VALID && n < WIDTH + 5) begin
            if (noise) begin
                A = WIDTH'($urandom); B = WIDTH'($urandom); BI = 1'($urandom);
                OUT_READY = 1'($urandom);
            end
            @(negedge CLK);
            n++;
        end
        cmp("latency", n, WIDTH);
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        d = D; bo = BO;
        repeat (stall) @(negedge CLK);
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        cmp("idle_in_ready", int'(IN_READY), 1);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             bo;
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; BI = 1'b0;
        repeat (2) @(negedge CLK);
        cmp("rst_in_ready", int'(IN_READY), 1);
        cmp("rst_out_valid", int'(OUT_VALID), 0);
        cmp("rst_d", int'(D), 0);
        RST = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 0, 0, d, bo);
        cmp("5a_3c_d", int'(d), 'h1E);
        cmp("5a_3c_bo", int'(bo), 0);
        run_op(8'h00, 8'hFF, 1'b0, 1, 0, d, bo);
        cmp("00_ff_d", int'(d), 'h01);
        cmp("00_ff_bo", int'(bo), 1);
        run_op(8'h80, 8'h80, 1'b0, 5, 0, d, bo);
        cmp("80_80_d", int'(d), 'h00);
        cmp("80_80_bo", int'(bo), 0);
        run_op(8'hC3, 8'h21, 1'b0, 2, 1, d, bo);
        cmp("noise_d", int'(d), 'hA2);
        cmp("noise_bo", int'(bo), 0);

        @(negedge CLK);
        A = 8'hF0; B = 8'h0F; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        cmp("abort_out_valid", int'(OUT_VALID), 0);
        cmp("abort_in_ready", int'(IN_READY), 1);
        cmp("abort_d", int'(D), 0);
        cmp("abort_bo", int'(BO), 0);
        run_op(8'h10, 8'h01, 1'b0, 0, 0, d, bo);
        cmp("10_01_d", int'(d), 'h0F);
        cmp("10_01_bo", int'(bo), 0);

`ifdef OSU_SERIAL_SUB_BORROW_IN_EN
        run_op(8'h00, 8'h00, 1'b1, 0, 0, d, bo);
        cmp("bi_00_00_d", int'(d), 'hFF);
        cmp("bi_00_00_bo", int'(bo), 1);
        run_op(8'h05, 8'h02, 1'b1, 0, 0, d, bo);
        cmp("bi_05_02_d", int'(d), 'h02);
        cmp("bi_05_02_bo", int'(bo), 0);
`endif

        for (int i = 0; i < 60; i++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), d, bo);

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
